// File: rtl/seq_priority_encoder_if.sv
// rtl/seq_priority_encoder_if.sv - request load / index handshake bundle for seq_priority_encoder
interface seq_priority_encoder_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
);
    logic             iLoad;
    logic [WIDTH-1:0] iData;
    logic             iReady;
    logic [IDX_W-1:0] oData;
    logic             oValid;
    logic             oBusy;
    logic             oNone;
    logic             oDone;

    modport master (
        output iLoad, iData, iReady,
        input  oData, oValid, oBusy, oNone, oDone
    );

    modport slave (
        input  iLoad, iData, iReady,
        output oData, oValid, oBusy, oNone, oDone
    );
endinterface

// File: rtl/seq_priority_encoder.sv
// rtl/seq_priority_encoder.sv - serialises a multi-hot request vector into indices, one per handshake
module seq_priority_encoder #(
    parameter int WIDTH     = 8,
    parameter int IDX_W     = 3,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    seq_priority_encoder_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pending, pending_nxt;
    logic [WIDTH-1:0] remaining;
    logic [IDX_W-1:0] data_q, data_nxt;
    logic             none_q, none_nxt;
    logic             done_q, done_nxt;

    // Later loop iterations overwrite earlier ones, so scan direction sets the winner.
    function automatic logic [IDX_W-1:0] prio(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        if (LSB_FIRST) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (v[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (v[i]) idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state   <= IDLE;
            pending <= '0;
            data_q  <= '0;
            none_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            data_q  <= data_nxt;
            none_q  <= none_nxt;
            done_q  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        data_nxt    = data_q;
        none_nxt    = 1'b0;
        done_nxt    = 1'b0;
        remaining   = pending & ~(WIDTH'(1) << data_q);
        case (state)
            IDLE: begin
                if (bus.iLoad) begin
                    if (|bus.iData) begin
                        pending_nxt = bus.iData;
                        data_nxt    = prio(bus.iData);
                        state_nxt   = SCAN;
                    end else begin
                        none_nxt = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (bus.iReady) begin
                    pending_nxt = remaining;
                    if (|remaining) begin
                        data_nxt = prio(remaining);
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // In this design valid and busy coincide: a scan always has a pending index.
    assign bus.oData  = data_q;
    assign bus.oValid = (state == SCAN);
    assign bus.oBusy  = (state == SCAN);
    assign bus.oNone  = none_q;
    assign bus.oDone  = done_q;

endmodule

// File: doc/seq_priority_encoder.md
Name: seq_priority_encoder

Overview:
Parametrised, registered successor to the combinational 8-3 encoder. It accepts a multi-hot request vector and serialises it: it emits the index of every set bit, one per accepted handshake, in priority order. It sits between request-collection logic (interrupt or flag latches) and a consumer that services one index at a time. An all-zero vector is flagged rather than encoded.

Parameters:
WIDTH, 8, number of request bits in iData (2..256).
IDX_W, 3, width of oData; must satisfy 2**IDX_W >= WIDTH.
LSB_FIRST, 0, priority order: 0 = highest index served first; 1 = lowest index first.

Ports:
iClk  input  1  clock; all state changes on the rising edge
iRst_n  input  1  asynchronous, active-low reset
iLoad  input  1  capture iData; honoured only while oBusy=0
iData  input  WIDTH  multi-hot request vector
iReady  input  1  consumer accepts the current oData
oData  output  IDX_W  index of the current highest-priority pending bit
oValid  output  1  oData is valid
oBusy  output  1  scan in progress; iLoad is ignored
oNone  output  1  one-cycle pulse: the loaded vector was all-zero
oDone  output  1  one-cycle pulse: last pending index accepted

Behaviour:
- Reset (iRst_n=0, asynchronous): state=IDLE, pending=0, oData=0, oValid=0, oBusy=0, oNone=0, oDone=0. Reset has effect immediately and takes priority mid-scan; a scan in flight is discarded with no oDone.
- FSM has two states: IDLE and SCAN.
- IDLE, iLoad=1, iData!=0: at the edge, pending<=iData and state<=SCAN. From the next cycle, oBusy=1, oValid=1 and oData=priority index of iData. Load-to-valid latency is 1 cycle.
- IDLE, iLoad=1, iData==0: oNone=1 for exactly the following cycle. State stays IDLE; oValid and oBusy stay 0.
- IDLE, iLoad=0: hold. oValid=0; oData holds its last value (don't-care).
- SCAN, oValid=1 and iReady=0: oData, oValid and pending hold stable. Changes on iData are ignored.
- SCAN, oValid=1 and iReady=1: at the edge, the bit at oData is cleared in pending.
  - If remaining bits are non-zero: oData updates to the next priority index in the next cycle, and oValid stays 1 (back-to-back, one index per cycle at full throughput).
  - If the remaining vector is zero: next cycle state=IDLE, oValid=0, oBusy=0, oDone=1 for one cycle.
- iLoad while oBusy=1 (including the final-accept cycle) is ignored with no capture. The new load is accepted from the cycle oBusy reads 0 (the oDone cycle).
- Priority: LSB_FIRST=0 selects the highest set index; LSB_FIRST=1 selects the lowest.
- oData is computed combinationally from the next-pending value and registered, so there is no comb path from iData or iReady to oData.
- oNone and oDone are never high in the same cycle. oValid=1 implies oBusy=1.
- Indices are zero-extended to IDX_W. Bits of pending at positions >= WIDTH do not exist.
- Number of oValid&&iReady handshakes per load equals popcount(iData).

Test Plan:
- Reset/one-hot sweep (WIDTH=8, LSB_FIRST=0), iReady=1: load 8'b00000001 through 8'b10000000 in turn -> oData=0..7, each oValid for 1 cycle, followed by oDone one cycle later.
- Multi-hot, MSB first: load 8'b10100110 with iReady=1 -> oData sequence 7,5,2,1 on consecutive cycles, then oDone=1. With LSB_FIRST=1 the sequence is 1,2,5,7.
- Backpressure: load 8'b00010010 and hold iReady=0 for 5 cycles -> oData=4 stays stable and oValid=1. Raise iReady for 1 cycle -> oData=1. Raise it again -> oDone=1.
- Zero vector and ignored load: load 8'h00 -> oNone pulses once and oValid stays 0. During a scan of 8'h81, assert iLoad with 8'h0F -> ignored, and the sequence remains 7,0.
- Async reset mid-scan: load 8'hFF, accept 3 indices, then drop iRst_n between edges -> all outputs 0 immediately with no oDone. After release, load 8'h40 -> oData=6.
- Wide config (WIDTH=32, IDX_W=5): load 32'h8000_0001 -> oData=31 then 0. Every load must produce handshake count equal to popcount.
